// File: rtl/prio_arbiter_4_if.sv
// Request/grant bundle between requesting blocks and the arbiter.
// The master drives requests, the slave returns grant state.
interface prio_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic [3:0] lock;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout,
    input  lock
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout,
    output lock
  );
endinterface

// File: rtl/prio_arbiter_4.sv
// Four-way fixed-priority arbiter, highest index wins, with hold
// limit and lockout of expired owners until they drop their request.
module prio_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  prio_arbiter_4_if.slave  bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       lock_q, lock_d;
  logic             to_q, to_d;

  logic [3:0]       elig;
  logic [1:0]       win;

  assign elig = bus.req & ~lock_q;

  always_comb begin
    win = 2'd0;
    if (elig[3])      win = 2'd3;
    else if (elig[2]) win = 2'd2;
    else if (elig[1]) win = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    // a dropped request always releases its lockout
    lock_d  = lock_q & bus.req;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = GRANT;
          owner_d = win;
          gnt_d   = 4'b0001 << win;
          cnt_d   = '0;
        end else begin
          owner_d = 2'd0;
          gnt_d   = 4'b0000;
        end
      end
      GRANT: begin
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          owner_d = 2'd0;
          gnt_d   = 4'b0000;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = IDLE;
          owner_d         = 2'd0;
          gnt_d           = 4'b0000;
          cnt_d           = '0;
          lock_d[owner_q] = 1'b1;
          to_d            = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      lock_q  <= 4'b0000;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      lock_q  <= lock_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = owner_q;
  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.timeout   = to_q;
  assign bus.lock      = lock_q;

endmodule

// File: doc/prio_arbiter_4.md
# prio_arbiter_4

Four-requester fixed-priority arbiter that shares a single downstream resource (bus port, encoder datapath, shared register) between requesters `req[0]`..`req[3]`. Arbitration uses the team's 4-to-2 priority ordering: the highest index wins. The arbiter holds a grant until the owner releases or a hold limit expires. Expired owners are locked out until they drop their request, which bounds how long any requester can monopolise the resource. It sits between the requesting blocks and the shared resource's select/enable inputs.

## Interface
- `HOLD_MAX`, 8: maximum consecutive grant cycles per tenure; legal range 2..255.
- `CNT_W`, 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  4  request per requester; level, held high while the resource is wanted.
- `gnt`  out  4  one-hot grant, registered; all-zero when idle.
- `gnt_id`  out  2  encoded index of the current owner; 0 when idle.
- `gnt_valid`  out  1  high while any grant is active (equals the OR of `gnt`).
- `timeout`  out  1  one-cycle pulse on the cycle a grant is revoked by the hold limit.
- `lock`  out  4  lockout mask; bit n high means requester n is excluded from arbitration.

## Operation
- States: IDLE, GRANT. Reset puts the block in IDLE.
- Reset values: `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0, `timeout` = 0, `lock` = 0, hold counter = 0.
- Eligible set is `req & ~lock`.
- IDLE:
  - If the eligible set is non-zero, go to GRANT.
  - Owner is the highest set bit of the eligible set (3 > 2 > 1 > 0).
  - Set `gnt` to the owner's one-hot bit, `gnt_id` to the owner index, and clear the counter.
  - If the eligible set is zero, stay in IDLE with all grant outputs 0.
- GRANT: each cycle, evaluate the following in order.
  - Release: if `req[owner]` = 0, go to IDLE, clear `gnt`, set `gnt_id` = 0, and leave `lock` unchanged.
  - Timeout: else if counter = HOLD_MAX-1, go to IDLE, clear `gnt`, set `lock[owner]` = 1, and pulse `timeout` for one cycle.
  - Otherwise: counter += 1 and the grant is held.
- No preemption: a higher-priority request arriving during GRANT waits for release or timeout.
- Lock clear: `lock[n]` clears on any edge where `req[n]` = 0.
  - This applies in both states and takes effect the next cycle.
  - Lock set and lock clear never coincide, because a timeout requires `req[owner]` = 1.
- Counter saturates logic-wise at HOLD_MAX-1. It never wraps.
- Reset is asynchronous and may occur mid-grant. All outputs, the lock mask and the counter go to their reset values immediately. The first grant after `rst_n` rises requires a fresh rising edge with a request present.
- X/Z on `req` is not a legal input; behaviour is undefined and is not checked.

## Timing
- Request to grant: 1 cycle. `req` is sampled at edge k; `gnt` is valid after edge k.
- Maximum tenure: exactly HOLD_MAX cycles of `gnt` high.
- Release to idle: `req[owner]` low sampled at edge k; `gnt` = 0 after edge k.
- Handover gap: the block always spends at least 1 cycle in IDLE (`gnt` = 0) between consecutive grants. This guarantees a break-before-make handover to the resource.
- `timeout` is high for the single cycle immediately following the revoking edge, coincident with the first IDLE cycle.
- All outputs are registered; there is no combinational path from `req` to any output.

## Test plan
- Reset:
  - Stimulus: `rst_n` = 0 with `req` = 4'b1111.
  - Response: `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0, `lock` = 0.
  - Stimulus: release reset.
  - Response: one edge later, `gnt` = 4'b1000 and `gnt_id` = 3.
- Priority:
  - Stimulus: from idle, `req` = 4'b0110.
  - Response: `gnt` = 4'b0100 and `gnt_id` = 2 after 1 edge.
  - Stimulus: drop `req[2]`.
  - Response: 1 idle cycle, then `gnt` = 4'b0010.
- No preemption:
  - Stimulus: owner 0 is granted, then `req[3]` rises.
  - Response: `gnt` stays 4'b0001 until `req[0]` falls, then 1 idle cycle, then `gnt` = 4'b1000.
- Timeout and lockout, with HOLD_MAX = 8:
  - Stimulus: `req` = 4'b1001 held constant.
  - Response: `gnt` = 4'b1000 for exactly 8 cycles, then `timeout` pulses once and `lock` = 4'b1000.
  - Response: 1 idle cycle, then `gnt` = 4'b0001.
  - Stimulus: `req[3]` is dropped for 1 cycle and reasserted.
  - Response: `lock` clears, and requester 3 wins the next IDLE arbitration.
- Reset mid-grant:
  - Stimulus: assert `rst_n` = 0 asynchronously at counter = 5 with a lock bit set.
  - Response: all outputs and `lock` go to 0 immediately, before the next clock edge.
- Random stress:
  - Stimulus: 10k cycles of random `req` under a hold-while-wanted discipline.
  - Response, checked every cycle:
    - `gnt` is one-hot or zero.
    - `gnt_id` matches `gnt`.
    - No tenure exceeds 8 cycles.
    - There is at least 1 idle cycle between grants.
    - A locked requester is never granted.
